// File: rtl/booth_mem_engine.sv
// Avalon-MM master: batch signed 32x32->64 Booth multiply over operand pairs in on-chip RAM.
// Latency: 37 cycles per pair (2 rd, 1 capture, 32 Booth steps, 2 wr); done 1 cycle after the last write.
// Backpressure: none; the RAM port is fixed-latency with no waitrequest, and start is ignored while busy.
module booth_mem_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 10240
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_MUL, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);

  state_t            state;
  logic [65:0]       p;
  logic [65:0]       p_step;
  logic [32:0]       upper_sum;
  logic [31:0]       a;
  logic [4:0]        it;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] dp;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W+1:0] src_end;
  logic [ADDR_W+1:0] dst_end;

  assign ram_byteenable = 4'hF;

  assign src_end = {2'b00, src_addr} + {1'b0, count, 1'b0};
  assign dst_end = {2'b00, dst_addr} + {1'b0, count, 1'b0};

  // One radix-2 Booth step: 33-bit upper part absorbs +/-A without overflow, then ASR by 1.
  always_comb begin
    upper_sum = p[65:33];
    if (p[1:0] == 2'b01) begin
      upper_sum = p[65:33] + {a[31], a};
    end else if (p[1:0] == 2'b10) begin
      upper_sum = p[65:33] - {a[31], a};
    end
    p_step = {upper_sum[32], upper_sum, p[32:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      p              <= '0;
      a              <= '0;
      it             <= '0;
      sp             <= '0;
      dp             <= '0;
      remaining      <= '0;
    end else begin
      done           <= 1'b0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              sp        <= src_addr;
              dp        <= dst_addr;
              remaining <= count;
              err       <= 1'b0;
              if (count == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else if (src_end > DEPTH_L || dst_end > DEPTH_L) begin
                err   <= 1'b1;
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state          <= S_RD_A;
                busy           <= 1'b1;
                ram_chipselect <= 1'b1;
                ram_address    <= src_addr;
              end
            end
          end
          S_RD_A: begin
            state          <= S_RD_B;
            ram_chipselect <= 1'b1;
            ram_address    <= sp + ADDR_W'(1);
          end
          S_RD_B: begin
            a     <= ram_readdata[31:0];
            state <= S_CAP_B;
          end
          S_CAP_B: begin
            p     <= {33'b0, ram_readdata[31:0], 1'b0};
            it    <= '0;
            state <= S_MUL;
          end
          S_MUL: begin
            p  <= p_step;
            it <= it + 5'd1;
            if (it == 5'd31) begin
              state          <= S_WR_LO;
              ram_chipselect <= 1'b1;
              ram_write      <= 1'b1;
              ram_address    <= dp;
              ram_writedata  <= DATA_W'(p_step[32:1]);
            end
          end
          S_WR_LO: begin
            state          <= S_WR_HI;
            ram_chipselect <= 1'b1;
            ram_write      <= 1'b1;
            ram_address    <= dp + ADDR_W'(1);
            ram_writedata  <= DATA_W'(p[64:33]);
          end
          S_WR_HI: begin
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              sp             <= sp + ADDR_W'(2);
              dp             <= dp + ADDR_W'(2);
              state          <= S_RD_A;
              ram_chipselect <= 1'b1;
              ram_address    <= sp + ADDR_W'(2);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_mem_engine.sv
// Directed bench for booth_mem_engine: vector table of single-pair batches plus multi-cycle corner sequences.
module tb_booth_mem_engine;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] count = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] ram_address;
  logic          ram_chipselect;
  logic          ram_write;
  logic [3:0]    ram_byteenable;
  logic [31:0]   ram_writedata;
  logic [31:0]   ram_readdata = '0;

  logic [31:0] mem [0:10239];
  int cyc = 0;
  int cs_cnt = 0;
  int wr_cnt = 0;
  int errors = 0;
  int checks = 0;
  logic logging = 1'b0;
  logic [2:0] trace [$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;
  vec_t vecs [8];

  booth_mem_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .busy(busy), .done(done), .err(err),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // RAM slave: writes land at the issuing edge, reads return on the following cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_chipselect) begin
      cs_cnt <= cs_cnt + 1;
      if (ram_write) begin
        mem[ram_address] = ram_writedata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
    if (logging) trace.push_back({busy, ram_chipselect, ram_write});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_batch(input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [AW-1:0] c, output int t0);
    @(negedge clk);
    src_addr = s; dst_addr = d; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, input int limit, output int lat);
    while (!done && (cyc - t0) < limit) @(negedge clk);
    lat = done ? (cyc - t0) : -1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int t0, lat, mism, cs0, wr0, seen;
    logic [2:0] e;
    logic [31:0] ra [8];
    logic [31:0] rb [8];
    longint pr;

    vecs[0] = '{32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1, 32'hFFFFFFFF};
    vecs[1] = '{32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
    vecs[2] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hC0000000};
    vecs[3] = '{32'h00000000, 32'h9ABCDEF0, 32'h00000000, 32'h00000000};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000001, 32'hFFFFFFFF};
    vecs[6] = '{32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001};
    vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF};

    #2;
    chk("reset_outputs", {busy, done, err, ram_chipselect, ram_write, ram_address, ram_writedata}, '0);
    chk("byteenable", {60'b0, ram_byteenable}, 64'hF);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Single-pair vectors; entry 0 uses the exact addresses of the first worked example.
    for (int i = 0; i < 8; i++) begin
      mem[16] = vecs[i].a; mem[17] = vecs[i].b;
      mem[32] = 32'hDEADBEEF; mem[33] = 32'hDEADBEEF;
      start_batch(14'h010, 14'h020, 14'd1, t0);
      chk($sformatf("v%0d_busy", i), {63'b0, busy}, 64'd1);
      wait_done(t0, 100, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd37);
      chk($sformatf("v%0d_lo", i), {32'b0, mem[32]}, {32'b0, vecs[i].lo});
      chk($sformatf("v%0d_hi", i), {32'b0, mem[33]}, {32'b0, vecs[i].hi});
      chk($sformatf("v%0d_busy_at_done", i), {63'b0, busy}, 64'd0);
    end

    // Eight random pairs in one batch against a plain 64-bit signed multiply.
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom; rb[i] = $urandom;
      mem[12'h200 + 2*i] = ra[i]; mem[12'h200 + 2*i + 1] = rb[i];
    end
    trace.delete();
    start_batch(14'h200, 14'h300, 14'd8, t0);
    logging = 1'b1;
    wait_done(t0, 400, lat);
    logging = 1'b0;
    chk("t3_latency", 64'(lat), 64'd296);
    chk("t3_trace_len", 64'(trace.size()), 64'd296);
    mism = 0;
    for (int j = 0; j < trace.size(); j++) begin
      if ((j % 37) < 2) e = 3'b110;
      else if ((j % 37) >= 35) e = 3'b111;
      else e = 3'b100;
      if (trace[j] !== e) mism++;
    end
    chk("t3_access_seq", 64'(mism), 64'd0);
    for (int i = 0; i < 8; i++) begin
      pr = longint'(int'(ra[i])) * longint'(int'(rb[i]));
      chk($sformatf("t3_prod%0d", i), {mem[12'h300 + 2*i + 1], mem[12'h300 + 2*i]}, pr);
    end

    // count=0 finishes immediately without touching the RAM.
    cs0 = cs_cnt;
    start_batch(14'h040, 14'h050, 14'd0, t0);
    wait_done(t0, 10, lat);
    chk("t4_cnt0_latency", 64'(lat), 64'd0);
    chk("t4_cnt0_err", {63'b0, err}, 64'd0);
    @(negedge clk);
    chk("t4_done_pulse", {63'b0, done}, 64'd0);
    chk("t4_cnt0_noaccess", 64'(cs_cnt - cs0), 64'd0);

    // Source range overrun.
    cs0 = cs_cnt;
    start_batch(14'd10238, 14'h050, 14'd2, t0);
    wait_done(t0, 10, lat);
    chk("t4_src_err_latency", 64'(lat), 64'd0);
    chk("t4_src_err", {63'b0, err}, 64'd1);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", {63'b0, err}, 64'd1);
    chk("t4_src_err_noaccess", 64'(cs_cnt - cs0), 64'd0);

    // Destination range overrun by one word.
    start_batch(14'h040, 14'd10239, 14'd1, t0);
    wait_done(t0, 10, lat);
    chk("t4_dst_err", {63'b0, err}, 64'd1);

    // Exactly at the top of RAM is legal and clears err.
    mem[10236] = 32'h00000007; mem[10237] = 32'hFFFFFFFE;
    mem[10238] = 32'h00010000; mem[10239] = 32'h00010000;
    start_batch(14'd10236, 14'h060, 14'd2, t0);
    @(negedge clk);
    chk("t4_err_cleared", {63'b0, err}, 64'd0);
    wait_done(t0, 200, lat);
    chk("t4_edge_latency", 64'(lat), 64'd74);
    chk("t4_edge_prod0", {mem[14'h061], mem[14'h060]}, 64'hFFFFFFFF_FFFFFFF2);
    chk("t4_edge_prod1", {mem[14'h063], mem[14'h062]}, 64'h00000001_00000000);

    // Abort in the 10th Booth step.
    mem[16] = 32'h00000005; mem[17] = 32'h00000006;
    mem[32] = 32'hDEADBEEF; mem[33] = 32'hDEADBEEF;
    wr0 = wr_cnt;
    start_batch(14'h010, 14'h020, 14'd1, t0);
    wait_until(t0 + 12);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_busy", {63'b0, busy}, 64'd0);
    seen = 0;
    repeat (40) begin
      if (done || ram_chipselect) seen++;
      @(negedge clk);
    end
    chk("t5_abort_quiet", 64'(seen), 64'd0);
    chk("t5_abort_nowrite", 64'(wr_cnt - wr0), 64'd0);
    chk("t5_abort_mem", {mem[33], mem[32]}, 64'hDEADBEEF_DEADBEEF);
    start_batch(14'h010, 14'h020, 14'd1, t0);
    wait_done(t0, 100, lat);
    chk("t5_rerun_latency", 64'(lat), 64'd37);
    chk("t5_rerun_prod", {mem[33], mem[32]}, 64'd30);

    // Abort while the low word is on the bus: only the low word lands.
    mem[32] = 32'hDEADBEEF; mem[33] = 32'hDEADBEEF;
    start_batch(14'h010, 14'h020, 14'd1, t0);
    wait_until(t0 + 35);
    chk("t5_wrlo_phase", {62'b0, ram_write, ram_chipselect}, 64'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_wrlo_busy", {63'b0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("t5_wrlo_mem", {mem[33], mem[32]}, 64'hDEADBEEF_0000001E);

    // Simultaneous start and abort in IDLE: start is dropped.
    cs0 = cs_cnt;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; count = 14'd1; src_addr = 14'h010; dst_addr = 14'h020;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t5_start_abort_busy", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    chk("t5_start_abort_idle", {63'b0, done}, 64'd0);
    chk("t5_start_abort_noaccess", 64'(cs_cnt - cs0), 64'd0);

    // start while busy is ignored and the running batch's parameters stand.
    mem[64] = 32'h11111111; mem[65] = 32'h22222222;
    mem[32] = 32'hDEADBEEF; mem[33] = 32'hDEADBEEF;
    mem[96] = 32'hCAFEF00D;
    start_batch(14'h010, 14'h020, 14'd1, t0);
    wait_until(t0 + 5);
    src_addr = 14'h040; dst_addr = 14'h060; count = 14'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, 100, lat);
    chk("t6_busy_start_latency", 64'(lat), 64'd37);
    chk("t6_busy_start_prod", {mem[33], mem[32]}, 64'd30);
    chk("t6_busy_start_other", {32'b0, mem[96]}, 64'hCAFEF00D);

    // Asynchronous reset during WR_HI.
    start_batch(14'h010, 14'h020, 14'd1, t0);
    wait_until(t0 + 36);
    chk("t6_wrhi_phase", {30'b0, ram_write, ram_chipselect, ram_address}, {30'b0, 2'b11, 14'h021});
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_reset", {busy, done, err, ram_chipselect, ram_write, ram_address, ram_writedata}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    mem[32] = 32'h0; mem[33] = 32'h0;
    start_batch(14'h010, 14'h020, 14'd1, t0);
    wait_done(t0, 100, lat);
    chk("t6_post_reset_prod", {mem[33], mem[32]}, 64'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
